// File: rtl/window_reducer.sv
// rtl/window_reducer.sv - reduces fixed windows of signed samples to SUM/MIN/MAX/AVG
// Two-state READ/WRITE controller with sync/notify handshakes on both sides.
module window_reducer #(
  parameter int WINDOW = 4,
  localparam int LOG2W = $clog2(WINDOW)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [31:0] in_data,
  input  logic               in_sync,
  output logic               in_notify,
  input  logic [1:0]         mode,
  output logic signed [31:0] out_data,
  output logic               out_sat,
  output logic               out_notify,
  input  logic               out_sync
);

  localparam int AW = 32 + LOG2W;

  typedef enum logic {S_READ, S_WRITE} state_t;

  state_t                r_state;
  logic [LOG2W-1:0]      r_count;
  logic signed [AW-1:0]  r_acc;
  logic signed [31:0]    r_min;
  logic signed [31:0]    r_max;
  logic [1:0]            r_mode;
  logic signed [31:0]    r_out_data;
  logic                  r_out_sat;
  logic                  r_in_notify;
  logic                  r_out_notify;

  logic                  w_first;
  logic                  w_last;
  logic signed [AW-1:0]  w_sample;
  logic signed [AW-1:0]  w_acc_next;
  logic signed [31:0]    w_min_next;
  logic signed [31:0]    w_max_next;
  logic [1:0]            w_mode_eff;
  logic [LOG2W:0]        w_acc_hi;
  logic                  w_overflow;
  logic signed [31:0]    w_sum_clamped;
  logic signed [31:0]    w_avg;
  logic signed [31:0]    w_result;
  logic                  w_result_sat;

  assign w_first    = (r_count == '0);
  assign w_last     = (r_count == LOG2W'(WINDOW - 1));
  assign w_sample   = {{LOG2W{in_data[31]}}, in_data};
  assign w_acc_next = w_first ? w_sample : r_acc + w_sample;
  assign w_min_next = (w_first || in_data < r_min) ? in_data : r_min;
  assign w_max_next = (w_first || in_data > r_max) ? in_data : r_max;
  assign w_mode_eff = w_first ? mode : r_mode;

  // Accumulator fits 32 bits only when everything from bit 31 up is a sign extension.
  assign w_acc_hi      = w_acc_next[AW-1:31];
  assign w_overflow    = !((&w_acc_hi) || !(|w_acc_hi));
  assign w_sum_clamped = !w_overflow ? w_acc_next[31:0]
                       : (w_acc_next[AW-1] ? 32'sh8000_0000 : 32'sh7FFF_FFFF);
  // Top 32 bits of the accumulator are exactly acc >>> LOG2W (floor toward -inf).
  assign w_avg         = w_acc_next[AW-1:LOG2W];

  always_comb begin
    w_result     = w_sum_clamped;
    w_result_sat = 1'b0;
    case (w_mode_eff)
      2'd0: begin
        w_result     = w_sum_clamped;
        w_result_sat = w_overflow;
      end
      2'd1: w_result = w_min_next;
      2'd2: w_result = w_max_next;
      2'd3: w_result = w_avg;
      default: w_result = w_sum_clamped;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_READ;
      r_count      <= '0;
      r_acc        <= '0;
      r_min        <= '0;
      r_max        <= '0;
      r_mode       <= 2'd0;
      r_out_data   <= '0;
      r_out_sat    <= 1'b0;
      r_in_notify  <= 1'b1;
      r_out_notify <= 1'b0;
    end else begin
      case (r_state)
        S_READ: begin
          if (in_sync && r_in_notify) begin
            r_acc   <= w_acc_next;
            r_min   <= w_min_next;
            r_max   <= w_max_next;
            r_mode  <= w_mode_eff;
            r_count <= r_count + 1'b1;
            if (w_last) begin
              r_out_data   <= w_result;
              r_out_sat    <= w_result_sat;
              r_out_notify <= 1'b1;
              r_in_notify  <= 1'b0;
              r_count      <= '0;
              r_state      <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (out_sync) begin
            r_out_notify <= 1'b0;
            r_in_notify  <= 1'b1;
            r_count      <= '0;
            r_state      <= S_READ;
          end
        end
        default: r_state <= S_READ;
      endcase
    end
  end

  assign in_notify  = r_in_notify;
  assign out_notify = r_out_notify;
  assign out_data   = r_out_data;
  assign out_sat    = r_out_sat;

endmodule

// File: tb/tb_window_reducer.sv
// tb/tb_window_reducer.sv - scoreboard bench for window_reducer
// Stimulus pushes expected results; a negedge monitor pops on each output transfer.
module tb_window_reducer;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_sync;
  logic        in_notify;
  logic [1:0]  mode;
  logic [31:0] out_data;
  logic        out_sat;
  logic        out_notify;
  logic        out_sync;

  int n_vec;
  int n_bad;

  typedef struct {
    logic [31:0] data;
    logic        sat;
    string       name;
  } exp_t;

  exp_t sb[$];

  window_reducer #(.WINDOW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sync    (in_sync),
    .in_notify  (in_notify),
    .mode       (mode),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .out_notify (out_notify),
    .out_sync   (out_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_notify && out_sync) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_result: got 0x%08h expected none", out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_data"}, out_data, e.data);
        chk({e.name, "_sat"}, {31'd0, out_sat}, {31'd0, e.sat});
      end
    end
  end

  task automatic expect_result(input string name, input logic [31:0] d, input logic s);
    exp_t e;
    e.name = name;
    e.data = d;
    e.sat  = s;
    sb.push_back(e);
  endtask

  task automatic send(input logic [31:0] d);
    int n;
    n = 0;
    in_data = d;
    in_sync = 1'b1;
    @(negedge clk);
    while (!in_notify && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_notify) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout: got in_notify=0 expected 1");
    end
    @(posedge clk);
    #1;
    in_sync = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic window4(input string name, input logic [1:0] m,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d,
                         input logic [31:0] ed, input logic es);
    expect_result(name, ed, es);
    mode = m;
    send(a);
    send(b);
    send(c);
    send(d);
    drain();
  endtask

  initial begin
    logic [31:0] held;
    n_vec    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    in_data  = '0;
    in_sync  = 1'b0;
    mode     = 2'd0;
    out_sync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_notify", {31'd0, in_notify}, 32'd1);
    chk("rst_out_notify", {31'd0, out_notify}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_sat", {31'd0, out_sat}, 32'd0);

    // SUM basic with handshake timing
    out_sync = 1'b1;
    mode     = 2'd0;
    expect_result("sum_basic", 32'd10, 1'b0);
    send(32'd1);
    send(32'd2);
    send(32'd3);
    send(32'd4);
    chk("t1_out_notify_hi", {31'd0, out_notify}, 32'd1);
    chk("t1_in_notify_lo", {31'd0, in_notify}, 32'd0);
    @(posedge clk);
    #1;
    chk("t1_in_notify_back", {31'd0, in_notify}, 32'd1);
    chk("t1_out_notify_lo", {31'd0, out_notify}, 32'd0);
    drain();

    window4("min", 2'd1, -32'sd5, 32'sd7, -32'sd9, 32'sd0, -32'sd9, 1'b0);
    window4("max", 2'd2, -32'sd5, 32'sd7, -32'sd9, 32'sd0, 32'sd7, 1'b0);
    window4("sat_pos", 2'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
            32'h7FFF_FFFF, 1'b1);
    window4("sat_neg", 2'd0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
            32'h8000_0000, 1'b1);
    window4("nosat_edge", 2'd0, 32'h7FFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0,
            32'h7FFF_FFFF, 1'b0);
    window4("avg_neg", 2'd3, -32'sd1, -32'sd2, 32'sd0, 32'sd0, -32'sd1, 1'b0);
    window4("avg_pos", 2'd3, 32'd5, 32'd5, 32'd5, 32'd6, 32'd5, 1'b0);

    // Backpressure: mode flips after first sample, output held, stray in_sync ignored
    out_sync = 1'b0;
    mode     = 2'd0;
    expect_result("mode_latch", 32'd100, 1'b0);
    send(32'd10);
    mode = 2'd1;
    send(32'd20);
    send(32'd30);
    send(32'd40);
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      in_data = 32'd1000;
      in_sync = i[0];
      @(posedge clk);
      #1;
      chk("bp_out_data_stable", out_data, held);
      chk("bp_in_notify_lo", {31'd0, in_notify}, 32'd0);
      chk("bp_out_notify_hi", {31'd0, out_notify}, 32'd1);
    end
    in_sync = 1'b0;
    mode    = 2'd0;
    expect_result("after_bp", 32'd10, 1'b0);
    in_data  = 32'd1;
    in_sync  = 1'b1;
    out_sync = 1'b1;
    send(32'd1);
    send(32'd2);
    send(32'd3);
    send(32'd4);
    drain();

    // Reset mid-window discards the partial window
    mode = 2'd0;
    send(32'd100);
    send(32'd200);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_in_notify", {31'd0, in_notify}, 32'd1);
    chk("midrst_out_notify", {31'd0, out_notify}, 32'd0);
    chk("midrst_out_data", out_data, 32'd0);
    window4("after_rst", 2'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd4, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL leftover_expected: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
